sand_stream: RTL and testbench

//  Animated successor to the single-column falling-sand pixel test in the hourglass VGA pipeline.

---
 rtl/sand_pkg.sv | 11 +
 rtl/sand_phase_ctr.sv | 53 +++++
 rtl/sand_stream.sv | 156 +++++++++++++++
 tb/tb_sand_stream.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sand_pkg.sv
// Shared constants for the falling-sand stream: state encoding and coordinate width.
package sand_pkg;

   localparam int unsigned COORD_W_DEF = 11;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FILL  = 2'd1;
   localparam logic [1:0] FLOW  = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

endpackage

// File: rtl/sand_phase_ctr.sv
// Row phase tracker: follows (visible_row - row_1 - offset) mod PERIOD without a divider.
module sand_phase_ctr
   import sand_pkg::*;
#(
   parameter int unsigned COORD_W = COORD_W_DEF,
   parameter int unsigned PERIOD  = 8,
   parameter int unsigned PH_W    = 3
) (
   input  logic               clk,
   input  logic               BTN_S,
   input  logic [COORD_W-1:0] visible_row,
   input  logic [COORD_W-1:0] row_1,
   input  logic [PH_W-1:0]    offset,
   output logic [PH_W-1:0]    phase_now_c
);

   localparam int unsigned PH_X = PH_W + 1;
   localparam logic [PH_W:0]   PERIOD_X = PH_X'(PERIOD);
   localparam logic [PH_W-1:0] PH_LAST  = PH_W'(PERIOD - 1);

   logic [COORD_W-1:0] prev_row;
   logic [PH_W-1:0]    row_phase;
   logic [PH_W-1:0]    phase_top;

   // Phase of the top row of the stream for the current offset.
   assign phase_top = PH_W'(PERIOD_X - {1'b0, offset});

   // Restart at the top row, step once per new row, otherwise hold.
   always_comb begin
      phase_now_c = row_phase;
      if (visible_row != prev_row) begin
         if (visible_row == row_1) begin
            phase_now_c = (offset == '0) ? '0 : phase_top;
         end else if (row_phase == PH_LAST) begin
            phase_now_c = '0;
         end else begin
            phase_now_c = row_phase + PH_W'(1);
         end
      end
   end

   // Row history and phase registers.
   always_ff @(posedge clk or posedge BTN_S) begin
      if (BTN_S) begin
         prev_row  <= '0;
         row_phase <= '0;
      end else begin
         prev_row  <= visible_row;
         row_phase <= phase_now_c;
      end
   end

endmodule

// File: rtl/sand_stream.sv
// Animated falling-sand stream in the hourglass neck: fill/flow/drain FSM and pixel hit.
module sand_stream
   import sand_pkg::*;
#(
   parameter int unsigned COORD_W   = COORD_W_DEF,
   parameter int unsigned STREAM_W  = 2,
   parameter int unsigned GRAIN_LEN = 3,
   parameter int unsigned GAP_LEN   = 5,
   parameter int unsigned SPEED     = 2
) (
   input  logic               clk,
   input  logic               BTN_S,
   input  logic               frame_tick,
   input  logic               run,
   input  logic [COORD_W-1:0] col,
   input  logic [COORD_W-1:0] row_1,
   input  logic [COORD_W-1:0] row_2,
   input  logic [COORD_W-1:0] visible_col,
   input  logic [COORD_W-1:0] visible_row,
   output logic               middle_sand,
   output logic [1:0]         stream_state,
   output logic               busy
);

   localparam int unsigned PERIOD = GRAIN_LEN + GAP_LEN;
   localparam int unsigned PH_W   = $clog2(PERIOD);
   localparam int unsigned PH_X   = PH_W + 1;
   localparam int unsigned EXT_W  = COORD_W + 1;
   localparam int unsigned SUM_W  = COORD_W + 2;

   localparam logic [SUM_W-1:0] SPEED_S  = SUM_W'(SPEED);
   localparam logic [PH_W:0]    SPEED_P  = PH_X'(SPEED);
   localparam logic [PH_W:0]    PERIOD_P = PH_X'(PERIOD);

   logic [1:0]       state, state_nxt;
   logic [PH_W-1:0]  offset, offset_nxt;
   logic [EXT_W-1:0] head, head_nxt;
   logic [EXT_W-1:0] tail, tail_nxt;

   logic [SUM_W-1:0] head_sum, tail_sum;
   logic [EXT_W-1:0] head_sat, tail_sat;
   logic [PH_W:0]    off_sum;
   logic [PH_W-1:0]  off_wrap;
   logic [EXT_W-1:0] span_c, r_c, col_hi_c;
   logic             in_col_c, in_row_c, grain_c, window_c, hit_c;
   logic [PH_W-1:0]  phase_now_c;

   // Saturating head/tail advance and modulo-PERIOD offset advance.
   always_comb begin
      head_sum = {1'b0, head} + SPEED_S;
      tail_sum = {1'b0, tail} + SPEED_S;
      head_sat = head_sum[SUM_W-1] ? '1 : head_sum[EXT_W-1:0];
      tail_sat = tail_sum[SUM_W-1] ? '1 : tail_sum[EXT_W-1:0];
      off_sum  = {1'b0, offset} + SPEED_P;
      off_wrap = (off_sum >= PERIOD_P) ? PH_W'(off_sum - PERIOD_P) : PH_W'(off_sum);
   end

   // Stream geometry; an inverted row range collapses to an empty span.
   always_comb begin
      span_c   = (row_2 >= row_1) ? ({1'b0, row_2} - {1'b0, row_1}) : '0;
      r_c      = {1'b0, visible_row} - {1'b0, row_1};
      col_hi_c = {1'b0, col} + EXT_W'(STREAM_W);
      in_col_c = ({1'b0, visible_col} >= {1'b0, col}) && ({1'b0, visible_col} < col_hi_c);
      in_row_c = (visible_row >= row_1) && (visible_row <= row_2);
      grain_c  = (phase_now_c < PH_W'(GRAIN_LEN));
   end

   // Next-state logic; everything advances only on frame_tick.
   always_comb begin
      state_nxt  = state;
      offset_nxt = offset;
      head_nxt   = head;
      tail_nxt   = tail;
      if (frame_tick) begin
         if (state != IDLE) begin
            offset_nxt = off_wrap;
         end
         case (state)
            IDLE: begin
               if (run) begin
                  state_nxt = FILL;
                  head_nxt  = '0;
               end
            end
            FILL: begin
               head_nxt = head_sat;
               if (!run) begin
                  state_nxt = DRAIN;
                  tail_nxt  = '0;
               end else if (head_sat >= span_c) begin
                  state_nxt = FLOW;
               end
            end
            FLOW: begin
               if (!run) begin
                  state_nxt = DRAIN;
                  tail_nxt  = '0;
               end
            end
            default: begin
               tail_nxt = tail_sat;
               if (tail_sat >= span_c) begin
                  state_nxt = IDLE;
               end
            end
         endcase
      end
   end

   // Visible window of the stream for the pre-edge state.
   always_comb begin
      window_c = 1'b0;
      case (state)
         FILL:    window_c = (r_c <= head);
         FLOW:    window_c = 1'b1;
         DRAIN:   window_c = (r_c > tail);
         default: window_c = 1'b0;
      endcase
      hit_c = in_col_c && in_row_c && grain_c && window_c;
   end

   // State, animation counters and registered outputs.
   always_ff @(posedge clk or posedge BTN_S) begin
      if (BTN_S) begin
         state       <= IDLE;
         offset      <= '0;
         head        <= '0;
         tail        <= '0;
         middle_sand <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         offset      <= offset_nxt;
         head        <= head_nxt;
         tail        <= tail_nxt;
         middle_sand <= hit_c;
         busy        <= (state_nxt != IDLE);
      end
   end

   assign stream_state = state;

   sand_phase_ctr #(
      .COORD_W (COORD_W),
      .PERIOD  (PERIOD),
      .PH_W    (PH_W)
   ) u_phase (
      .clk         (clk),
      .BTN_S       (BTN_S),
      .visible_row (visible_row),
      .row_1       (row_1),
      .offset      (offset),
      .phase_now_c (phase_now_c)
   );

endmodule

// File: tb/tb_sand_stream.sv
// Directed bench for sand_stream: vector table plus multi-cycle fill/drain/reset sequences.
module tb_sand_stream;

   localparam int P     = 8;
   localparam int SPD   = 2;
   localparam int GRAIN = 3;
   localparam int SW    = 2;

   logic        clk;
   logic        BTN_S;
   logic        frame_tick;
   logic        run;
   logic [10:0] col, row_1, row_2, visible_col, visible_row;
   logic        middle_sand;
   logic [1:0]  stream_state;
   logic        busy;

   int checks;
   int errors;

   // bench model of the animation state
   int m_state, m_off, m_head, m_tail;

   typedef struct {
      bit tick;
      int row;
      int col;
      bit exp;
   } vec_t;

   vec_t tbl[20];

   sand_stream dut (
      .clk          (clk),
      .BTN_S        (BTN_S),
      .frame_tick   (frame_tick),
      .run          (run),
      .col          (col),
      .row_1        (row_1),
      .row_2        (row_2),
      .visible_col  (visible_col),
      .visible_row  (visible_row),
      .middle_sand  (middle_sand),
      .stream_state (stream_state),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int span_of();
      if (int'(row_2) < int'(row_1)) return 0;
      return int'(row_2) - int'(row_1);
   endfunction

   function automatic int exp_pix(input int c, input int rr);
      int r, ph;
      bit win;
      if (rr < int'(row_1) || rr > int'(row_2)) return 0;
      if (c < int'(col) || c >= int'(col) + SW) return 0;
      r  = rr - int'(row_1);
      ph = ((r % P) + P - m_off) % P;
      case (m_state)
         1: win = (r <= m_head);
         2: win = 1'b1;
         3: win = (r > m_tail);
         default: win = 1'b0;
      endcase
      return (win && ph < GRAIN) ? 1 : 0;
   endfunction

   task automatic do_tick(input logic run_v);
      int span;
      span = span_of();
      @(negedge clk);
      frame_tick = 1'b1;
      run        = run_v;
      @(negedge clk);
      frame_tick = 1'b0;
      if (m_state != 0) m_off = (m_off + SPD) % P;
      case (m_state)
         0: if (run_v) begin m_state = 1; m_head = 0; end
         1: begin
            m_head = (m_head + SPD > 4095) ? 4095 : m_head + SPD;
            if (!run_v) begin m_state = 3; m_tail = 0; end
            else if (m_head >= span) m_state = 2;
         end
         2: if (!run_v) begin m_state = 3; m_tail = 0; end
         default: begin
            m_tail = (m_tail + SPD > 4095) ? 4095 : m_tail + SPD;
            if (m_tail >= span) m_state = 0;
         end
      endcase
   endtask

   task automatic pix(input int c, input int r, output logic ms);
      @(negedge clk);
      visible_col = 11'(c);
      visible_row = 11'(r);
      @(posedge clk);
      #1 ms = middle_sand;
   endtask

   task automatic scan_check(input string name, input int c, input int lo, input int hi);
      logic ms;
      for (int r = lo; r <= hi; r++) begin
         pix(c, r, ms);
         check($sformatf("%s row %0d", name, r), int'(ms), exp_pix(c, r));
      end
   endtask

   initial begin
      logic ms;
      bit   found;
      checks = 0;
      errors = 0;
      m_state = 0; m_off = 0; m_head = 0; m_tail = 0;

      tbl[0]  = '{1'b0, 199, 321, 1'b0};
      tbl[1]  = '{1'b0, 200, 321, 1'b1};
      tbl[2]  = '{1'b0, 200, 320, 1'b1};
      tbl[3]  = '{1'b0, 200, 322, 1'b0};
      tbl[4]  = '{1'b0, 200, 319, 1'b0};
      tbl[5]  = '{1'b0, 201, 321, 1'b1};
      tbl[6]  = '{1'b0, 202, 321, 1'b1};
      tbl[7]  = '{1'b0, 203, 321, 1'b0};
      tbl[8]  = '{1'b0, 204, 321, 1'b0};
      tbl[9]  = '{1'b0, 205, 321, 1'b0};
      tbl[10] = '{1'b0, 206, 321, 1'b0};
      tbl[11] = '{1'b0, 207, 321, 1'b0};
      tbl[12] = '{1'b0, 208, 321, 1'b1};
      tbl[13] = '{1'b1, 199, 321, 1'b0};
      tbl[14] = '{1'b0, 200, 321, 1'b0};
      tbl[15] = '{1'b0, 201, 321, 1'b0};
      tbl[16] = '{1'b0, 202, 321, 1'b1};
      tbl[17] = '{1'b0, 203, 321, 1'b1};
      tbl[18] = '{1'b0, 204, 321, 1'b1};
      tbl[19] = '{1'b0, 205, 321, 1'b0};

      BTN_S       = 1'b1;
      frame_tick  = 1'b0;
      run         = 1'b0;
      col         = 11'd320;
      row_1       = 11'd200;
      row_2       = 11'd239;
      visible_col = 11'd0;
      visible_row = 11'd0;
      repeat (3) @(negedge clk);
      check("reset middle_sand", int'(middle_sand), 0);
      check("reset state", int'(stream_state), 0);
      check("reset busy", int'(busy), 0);
      BTN_S = 1'b0;

      // idle: nothing drawn
      pix(320, 200, ms);
      pix(320, 210, ms);
      check("idle pixel", int'(ms), 0);
      check("idle busy", int'(busy), 0);

      // fill from the top
      do_tick(1'b1);
      check("fill state", int'(stream_state), 1);
      check("fill busy", int'(busy), 1);
      scan_check("fill head0", 321, 199, 241);
      repeat (19) do_tick(1'b1);
      check("fill after 19", int'(stream_state), 1);
      do_tick(1'b1);
      check("flow after 20", int'(stream_state), 2);
      check("model offset 0", m_off, 0);

      // grain pattern vectors, offset 0 then offset 2
      for (int i = 0; i < 20; i++) begin
         if (tbl[i].tick) do_tick(1'b1);
         pix(tbl[i].col, tbl[i].row, ms);
         check($sformatf("vec%0d (%0d,%0d)", i, tbl[i].col, tbl[i].row), int'(ms), int'(tbl[i].exp));
      end

      // offset wrap 6 -> 0
      do_tick(1'b1);
      do_tick(1'b1);
      scan_check("flow off6", 320, 199, 241);
      do_tick(1'b1);
      scan_check("flow wrap", 321, 199, 241);

      // drain out of the bottom; run ignored while draining
      do_tick(1'b0);
      check("drain state", int'(stream_state), 3);
      scan_check("drain tail0", 320, 199, 241);
      do_tick(1'b0);
      scan_check("drain tail2", 321, 199, 241);
      repeat (18) do_tick(1'b0);
      check("drain after 19", int'(stream_state), 3);
      check("drain busy", int'(busy), 1);
      do_tick(1'b1);
      check("drain to idle", int'(stream_state), 0);
      check("idle busy after drain", int'(busy), 0);

      // asynchronous reset mid-flow, mid-line on a lit pixel
      do_tick(1'b1);
      repeat (20) do_tick(1'b1);
      check("reflow state", int'(stream_state), 2);
      found = 1'b0;
      for (int r = 199; r <= 210 && !found; r++) begin
         pix(320, r, ms);
         check($sformatf("preset row %0d", r), int'(ms), exp_pix(320, r));
         if (exp_pix(320, r) == 1) found = 1'b1;
      end
      check("lit pixel found", int'(found), 1);
      @(posedge clk);
      #2 BTN_S = 1'b1;
      #1;
      check("async rst middle_sand", int'(middle_sand), 0);
      check("async rst state", int'(stream_state), 0);
      check("async rst busy", int'(busy), 0);
      @(negedge clk);
      BTN_S = 1'b0;
      m_state = 0; m_off = 0; m_head = 0; m_tail = 0;

      // inverted row range: never sand
      row_2 = 11'd150;
      do_tick(1'b1);
      do_tick(1'b1);
      do_tick(1'b1);
      for (int r = 140; r <= 245; r++) begin
         pix(320, r, ms);
         check($sformatf("empty c320 row %0d", r), int'(ms), 0);
         pix(321, r, ms);
         check($sformatf("empty c321 row %0d", r), int'(ms), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
